// File: rtl/func_loader_if.sv
// Byte-stream and issue-side signal bundle for func_loader.
// The master drives bytes, hold and flush; the slave returns ready, func, new_func and count.
interface func_loader_if #(
    parameter int DEPTH = 4
);
    logic                     flush;
    logic                     hold;
    logic [7:0]               byte_in;
    logic                     byte_valid;
    logic                     byte_ready;
    logic [23:0]              func;
    logic                     new_func;
    logic [$clog2(DEPTH):0]   count;

    modport master (
        output flush, hold, byte_in, byte_valid,
        input  byte_ready, func, new_func, count
    );

    modport slave (
        input  flush, hold, byte_in, byte_valid,
        output byte_ready, func, new_func, count
    );
endinterface

// File: rtl/func_loader.sv
// Assembles MSB-first bytes into 24-bit instruction words, queues them, and
// issues one word at a time on func with a new_func pulse spaced by GAP cycles.
module func_loader #(
    parameter int DEPTH = 4,
    parameter int GAP   = 4
) (
    input  logic         clk,
    input  logic         reset,
    func_loader_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] WAIT = 1'b1;

    logic [1:0]    idx;
    logic [15:0]   hi;
    logic [23:0]   mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic [CW-1:0] cnt;
    logic [0:0]    state;
    logic [GW-1:0] gcnt;
    logic [23:0]   func_q;
    logic          nf_q;

    logic full, empty, accept, push, pop;

    assign full   = (cnt == CW'(DEPTH));
    assign empty  = (cnt == '0);
    // Ready only drops on the word-completing byte; a same-cycle pop does not help.
    assign bus.byte_ready = !((idx == 2'd2) && full);
    assign accept = bus.byte_valid && bus.byte_ready && !bus.flush;
    assign push   = accept && (idx == 2'd2);
    assign pop    = (state == IDLE) && !empty && !bus.hold && !bus.flush;

    assign bus.func     = func_q;
    assign bus.new_func = nf_q;
    assign bus.count    = cnt;

    always_ff @(posedge clk) begin
        if (push) mem[wp] <= {hi, bus.byte_in};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx    <= 2'd0;
            hi     <= '0;
            wp     <= '0;
            rp     <= '0;
            cnt    <= '0;
            state  <= IDLE;
            gcnt   <= '0;
            func_q <= '0;
            nf_q   <= 1'b0;
        end else if (bus.flush) begin
            idx   <= 2'd0;
            wp    <= '0;
            rp    <= '0;
            cnt   <= '0;
            state <= IDLE;
            gcnt  <= '0;
            nf_q  <= 1'b0;
        end else begin
            if (accept) begin
                case (idx)
                    2'd0:    hi[15:8] <= bus.byte_in;
                    2'd1:    hi[7:0]  <= bus.byte_in;
                    default: ;
                endcase
                idx <= (idx == 2'd2) ? 2'd0 : idx + 2'd1;
            end
            if (push) wp <= wp + AW'(1);
            if (pop)  rp <= rp + AW'(1);
            case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: ;
            endcase

            case (state)
                IDLE: begin
                    if (pop) begin
                        func_q <= mem[rp];
                        nf_q   <= 1'b1;
                        gcnt   <= GW'(GAP - 1);
                        if (GAP > 1) state <= WAIT;
                    end else begin
                        nf_q <= 1'b0;
                    end
                end
                default: begin
                    nf_q <= 1'b0;
                    gcnt <= gcnt - GW'(1);
                    if (gcnt <= GW'(1)) state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_func_loader.sv
// Directed bench for func_loader: a GAP=4 instance for the main scenarios and a
// GAP=1 instance for back-to-back issue.
module tb_func_loader;
    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   nvec = 0;
    int   nfail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    func_loader_if #(.DEPTH(4)) ifa ();
    func_loader_if #(.DEPTH(4)) ifb ();

    func_loader #(.DEPTH(4), .GAP(4)) dut_a (.clk(clk), .reset(reset), .bus(ifa.slave));
    func_loader #(.DEPTH(4), .GAP(1)) dut_b (.clk(clk), .reset(reset), .bus(ifb.slave));

    int          pt[$];
    logic [23:0] pf[$];

    always @(negedge clk) begin
        if (reset === 1'b1 && ifa.new_func === 1'b1) begin
            pt.push_back(cyc);
            pf.push_back(ifa.func);
        end
    end

    typedef struct {
        logic [7:0]  b0, b1, b2;
        logic [23:0] exp_func;
        int          exp_gap;
    } vec_t;

    vec_t tv[3];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tmo(input string nm);
        nvec++;
        nfail++;
        $display("FAIL %s: expected event did not occur within bound", nm);
    endtask

    task automatic send(input bit b, input logic [7:0] d);
        int n = 0;
        if (b) begin ifb.byte_valid = 1'b1; ifb.byte_in = d; end
        else   begin ifa.byte_valid = 1'b1; ifa.byte_in = d; end
        while (!(b ? ifb.byte_ready : ifa.byte_ready) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) tmo("send_ready");
        @(negedge clk);
        if (b) ifb.byte_valid = 1'b0; else ifa.byte_valid = 1'b0;
    endtask

    task automatic send_word(input bit b, input logic [23:0] w);
        send(b, w[23:16]);
        send(b, w[15:8]);
        send(b, w[7:0]);
    endtask

    task automatic wait_pulse(input string nm);
        int n = 0;
        while (ifa.new_func !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) tmo(nm);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tv[0] = '{8'hA0, 8'h00, 8'h01, 24'hA00001, 0};
        tv[1] = '{8'hA0, 8'h00, 8'h02, 24'hA00002, 4};
        tv[2] = '{8'hA0, 8'h00, 8'h03, 24'hA00003, 4};

        reset = 1'b0;
        ifa.flush = 0; ifa.hold = 0; ifa.byte_in = 0; ifa.byte_valid = 0;
        ifb.flush = 0; ifb.hold = 0; ifb.byte_in = 0; ifb.byte_valid = 0;
        #12;
        chk("rst_func",     32'(ifa.func), 0);
        chk("rst_new_func", 32'(ifa.new_func), 0);
        chk("rst_count",    32'(ifa.count), 0);
        chk("rst_ready",    32'(ifa.byte_ready), 1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Single word latency
        send_word(0, 24'h123456);
        chk("lat_count_after_push", 32'(ifa.count), 1);
        chk("lat_no_early_pulse",   32'(ifa.new_func), 0);
        @(negedge clk);
        chk("lat_pulse", 32'(ifa.new_func), 1);
        chk("lat_func",  32'(ifa.func), 32'h123456);
        chk("lat_count", 32'(ifa.count), 0);
        @(negedge clk);
        chk("lat_pulse_one_cycle", 32'(ifa.new_func), 0);

        // Back-to-back words, GAP spacing
        pt.delete(); pf.delete();
        for (int i = 0; i < 3; i++) begin
            send(0, tv[i].b0); send(0, tv[i].b1); send(0, tv[i].b2);
        end
        repeat (20) @(negedge clk);
        chk("b2b_pulse_count", 32'(pt.size()), 3);
        for (int i = 0; i < 3; i++) begin
            if (i < pt.size()) begin
                chk($sformatf("b2b_func[%0d]", i), 32'(pf[i]), 32'(tv[i].exp_func));
                if (i > 0) chk($sformatf("b2b_gap[%0d]", i), 32'(pt[i] - pt[i-1]), 32'(tv[i].exp_gap));
            end else begin
                tmo($sformatf("b2b_pulse[%0d]", i));
            end
        end

        // hold with full FIFO and a partial fifth word
        pt.delete(); pf.delete();
        ifa.hold = 1'b1;
        for (int i = 1; i <= 4; i++) send_word(0, 24'hB00000 | 24'(i));
        send(0, 8'hB0);
        send(0, 8'h00);
        chk("hold_count_full", 32'(ifa.count), 4);
        chk("hold_ready_low",  32'(ifa.byte_ready), 0);
        chk("hold_no_pulse",   32'(pt.size()), 0);
        ifa.hold = 1'b0;
        ifa.byte_valid = 1'b1;
        ifa.byte_in = 8'h05;
        @(negedge clk);
        chk("hold_rel_pulse", 32'(ifa.new_func), 1);
        chk("hold_rel_func",  32'(ifa.func), 32'hB00001);
        chk("hold_rel_count", 32'(ifa.count), 3);
        chk("hold_rel_ready", 32'(ifa.byte_ready), 1);
        @(negedge clk);
        ifa.byte_valid = 1'b0;
        chk("hold_refill_count", 32'(ifa.count), 4);
        repeat (30) @(negedge clk);
        chk("hold_drain_pulses", 32'(pt.size()), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < pt.size()) chk($sformatf("hold_func[%0d]", i), 32'(pf[i]), 32'hB00001 + 32'(i));
        end

        // flush with count=3 and byte index=1
        ifa.hold = 1'b1;
        for (int i = 1; i <= 3; i++) send_word(0, 24'hC00000 | 24'(i));
        send(0, 8'hEE);
        chk("flush_pre_count", 32'(ifa.count), 3);
        ifa.flush = 1'b1;
        ifa.byte_valid = 1'b1;
        ifa.byte_in = 8'h77;
        @(negedge clk);
        ifa.flush = 1'b0;
        ifa.byte_valid = 1'b0;
        chk("flush_count",    32'(ifa.count), 0);
        chk("flush_new_func", 32'(ifa.new_func), 0);
        chk("flush_func_kept", 32'(ifa.func), 32'hB00005);
        chk("flush_ready",    32'(ifa.byte_ready), 1);
        send_word(0, 24'hC1C2C3);
        chk("flush_refill_count", 32'(ifa.count), 1);
        ifa.hold = 1'b0;
        wait_pulse("flush_pulse");
        chk("flush_next_func", 32'(ifa.func), 32'hC1C2C3);
        repeat (6) @(negedge clk);

        // asynchronous reset during WAIT
        send_word(0, 24'hD1D2D3);
        wait_pulse("rst_mid_pulse");
        chk("rst_mid_pre_func", 32'(ifa.func), 32'hD1D2D3);
        ifa.hold = 1'b1;
        send(0, 8'hE0);
        #2;
        reset = 1'b0;
        #1;
        chk("rst_mid_func",     32'(ifa.func), 0);
        chk("rst_mid_new_func", 32'(ifa.new_func), 0);
        chk("rst_mid_count",    32'(ifa.count), 0);
        chk("rst_mid_ready",    32'(ifa.byte_ready), 1);
        @(negedge clk);
        reset = 1'b1;
        ifa.hold = 1'b0;
        send_word(0, 24'hE1E2E3);
        @(negedge clk);
        chk("rst_after_pulse", 32'(ifa.new_func), 1);
        chk("rst_after_func",  32'(ifa.func), 32'hE1E2E3);

        // GAP=1 back-to-back issue
        ifb.hold = 1'b1;
        send_word(1, 24'hF10203);
        send_word(1, 24'hF40506);
        chk("g1_count", 32'(ifb.count), 2);
        chk("g1_no_pulse", 32'(ifb.new_func), 0);
        ifb.hold = 1'b0;
        @(negedge clk);
        chk("g1_pulse0", 32'(ifb.new_func), 1);
        chk("g1_func0",  32'(ifb.func), 32'hF10203);
        @(negedge clk);
        chk("g1_pulse1", 32'(ifb.new_func), 1);
        chk("g1_func1",  32'(ifb.func), 32'hF40506);
        chk("g1_count_end", 32'(ifb.count), 0);
        @(negedge clk);
        chk("g1_pulse_end", 32'(ifb.new_func), 0);
        chk("g1_func_hold", 32'(ifb.func), 32'hF40506);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
